// File: rtl/brisc_mul_pipe.sv
// Fixed-latency multiplier pipe with valid/ready handshake, kill flush and tag carry.
// Define BRISC_MUL_HIGH_EN to enable MULH/MULHSU/MULHU; otherwise every op returns the low word.
module brisc_mul_pipe #(
   parameter int XLEN  = 32,
   parameter int DELAY = 5,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [1:0]       op_i,
   input  logic [XLEN-1:0]  a_i,
   input  logic [XLEN-1:0]  b_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             kill_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [XLEN-1:0]  result_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             busy_o
);

   logic [DELAY-1:0] stage_valid;
   logic [TAG_W-1:0] stage_tag  [DELAY];
   logic [XLEN-1:0]  stage_word [DELAY];
   logic [XLEN-1:0]  issue_word;
   logic             advance;

`ifdef BRISC_MUL_HIGH_EN
   logic                   a_signed;
   logic                   b_signed;
   logic [2*XLEN-1:0]      a_ext;
   logic [2*XLEN-1:0]      b_ext;
   logic [2*XLEN-1:0]      product;

   // Extending both operands to 2*XLEN makes a plain truncating multiply exact for every sign mix.
   assign a_signed   = op_i[0] ^ op_i[1];
   assign b_signed   = (op_i == 2'b01);
   assign a_ext      = {{XLEN{a_signed & a_i[XLEN-1]}}, a_i};
   assign b_ext      = {{XLEN{b_signed & b_i[XLEN-1]}}, b_i};
   assign product    = a_ext * b_ext;
   assign issue_word = (op_i == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
`else
   logic unused_op;

   assign unused_op  = ^op_i;
   assign issue_word = a_i * b_i;
`endif

   assign valid_o  = stage_valid[DELAY-1];
   assign advance  = !valid_o || ready_i;
   assign ready_o  = advance;
   assign busy_o   = |stage_valid;
   assign result_o = stage_word[DELAY-1];
   assign tag_o    = stage_tag[DELAY-1];

   // The whole pipe moves as one shift register; a stalled output freezes every stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_valid <= '0;
         for (int i = 0; i < DELAY; i++) begin
            stage_tag[i]  <= '0;
            stage_word[i] <= '0;
         end
      end else if (kill_i) begin
         stage_valid <= '0;
      end else if (advance) begin
         stage_valid[0] <= valid_i;
         stage_tag[0]   <= tag_i;
         stage_word[0]  <= issue_word;
         for (int i = 1; i < DELAY; i++) begin
            stage_valid[i] <= stage_valid[i-1];
            stage_tag[i]   <= stage_tag[i-1];
            stage_word[i]  <= stage_word[i-1];
         end
      end
   end

endmodule

// File: tb/tb_brisc_mul_pipe.sv
// Directed self-checking bench for brisc_mul_pipe (DELAY=5, XLEN=32, TAG_W=5).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_brisc_mul_pipe;

   logic        clk;
   logic        rst_n;
   logic        valid_i;
   logic        ready_o;
   logic [1:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [4:0]  tag_i;
   logic        kill_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic [4:0]  tag_o;
   logic        busy_o;

   int checkCount = 0;
   int passCount  = 0;

   brisc_mul_pipe #(.XLEN(32), .DELAY(5), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .op_i(op_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .kill_i(kill_i),
      .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
      .tag_o(tag_o), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation hung");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] tg);
      valid_i = v;
      op_i    = op;
      a_i     = a;
      b_i     = b;
      tag_i   = tg;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one op with ready_i=1, then wait (bounded) for its result and check word, tag, latency.
   task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg, input logic [31:0] expected);
      int lat;
      lat = 0;
      ready_i = 1'b1;
      applyStimulus(1'b1, op, a, b, tg);
      nextCycle();
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (valid_o) begin
            lat = n;
            break;
         end
         nextCycle();
      end
      if (lat == 0) begin
         checkOutput({name, "_timeout"}, 32'h0, 32'h1);
      end else begin
         checkOutput({name, "_result"}, result_o, expected);
         checkOutput({name, "_tag"}, {27'h0, tag_o}, {27'h0, tg});
         checkOutput({name, "_latency"}, lat, 32'd5);
         nextCycle();
      end
   endtask

   initial begin
      int seen;
      rst_n   = 1'b0;
      kill_i  = 1'b0;
      ready_i = 1'b1;
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);

      #12;
      checkOutput("reset_valid_o", {31'h0, valid_o}, 32'h0);
      checkOutput("reset_busy_o", {31'h0, busy_o}, 32'h0);
      checkOutput("reset_ready_o", {31'h0, ready_o}, 32'h1);
      checkOutput("reset_result_o", result_o, 32'h0);
      checkOutput("reset_tag_o", {27'h0, tag_o}, 32'h0);
      nextCycle();
      rst_n = 1'b1;
      nextCycle();

      // Basic latency: valid_o only in cycle 5
      applyStimulus(1'b1, 2'b00, 32'd3, 32'd7, 5'd5);
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         checkOutput($sformatf("lat_valid_c%0d", c), {31'h0, valid_o}, (c == 5) ? 32'h1 : 32'h0);
         if (c == 5) begin
            checkOutput("lat_result", result_o, 32'd21);
            checkOutput("lat_tag", {27'h0, tag_o}, 32'd5);
         end
         nextCycle();
         applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
      end

      runOp("big_low", 2'b00, 32'h12345678, 32'h10, 5'd9, 32'h23456780);
`ifdef BRISC_MUL_HIGH_EN
      runOp("mulh_m1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000000);
      runOp("mulhu_m1", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE);
      runOp("mulhsu_m1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF);
      runOp("mul_m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000001);
      runOp("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000);
      runOp("mulh_neg2", 2'b01, 32'h80000000, 32'd2, 5'd7, 32'hFFFFFFFF);
`else
      runOp("lowonly_op11", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000001);
      runOp("lowonly_op10", 2'b10, 32'hFFFFFFFF, 32'h00000003, 5'd3, 32'hFFFFFFFD);
      runOp("lowonly_op01", 2'b01, 32'h80000000, 32'd2, 5'd7, 32'h00000000);
`endif

      // Back-pressure: three ops, ready_i low in cycles 5..9
      for (int c = 0; c <= 13; c++) begin
         if (c < 3) applyStimulus(1'b1, 2'b00, c + 1, 32'd1, 5'(c + 1));
         else applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
         ready_i = !(c >= 5 && c <= 9);
         @(negedge clk);
         if (c == 4) checkOutput("bp_pre_valid", {31'h0, valid_o}, 32'h0);
         if (c >= 5 && c <= 9) begin
            checkOutput($sformatf("bp_ready_c%0d", c), {31'h0, ready_o}, 32'h0);
            checkOutput($sformatf("bp_hold_result_c%0d", c), result_o, 32'd1);
            checkOutput($sformatf("bp_hold_valid_c%0d", c), {31'h0, valid_o}, 32'h1);
         end
         if (c == 9) checkOutput("bp_hold_tag", {27'h0, tag_o}, 32'd1);
         if (c >= 10 && c <= 12) begin
            checkOutput($sformatf("bp_valid_c%0d", c), {31'h0, valid_o}, 32'h1);
            checkOutput($sformatf("bp_result_c%0d", c), result_o, c - 9);
            checkOutput($sformatf("bp_tag_c%0d", c), {27'h0, tag_o}, c - 9);
         end
         if (c == 13) checkOutput("bp_drained", {31'h0, valid_o}, 32'h0);
         nextCycle();
      end

      // Kill in cycle 2 with two ops in flight and a third offered
      ready_i = 1'b1;
      seen = 0;
      for (int c = 0; c <= 10; c++) begin
         applyStimulus(c <= 2, 2'b00, 32'd5, 32'd5, 5'(c + 10));
         kill_i = (c == 2);
         @(negedge clk);
         if (valid_o) seen++;
         if (c == 2) checkOutput("kill_busy_before", {31'h0, busy_o}, 32'h1);
         if (c == 3) checkOutput("kill_busy_after", {31'h0, busy_o}, 32'h0);
         nextCycle();
      end
      kill_i = 1'b0;
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
      checkOutput("kill_no_valid", seen, 32'h0);

      // Asynchronous reset in cycle 3 with ops in flight
      seen = 0;
      for (int c = 0; c <= 3; c++) begin
         applyStimulus(c < 3, 2'b00, 32'd6, 32'd6, 5'(c + 20));
         if (c < 3) nextCycle();
      end
      @(negedge clk);
      checkOutput("rst_busy_before", {31'h0, busy_o}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_valid_now", {31'h0, valid_o}, 32'h0);
      checkOutput("rst_busy_now", {31'h0, busy_o}, 32'h0);
      checkOutput("rst_ready_now", {31'h0, ready_o}, 32'h1);
      nextCycle();
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (valid_o || busy_o) seen++;
         nextCycle();
      end
      checkOutput("rst_no_stale", seen, 32'h0);

      runOp("post_reset", 2'b00, 32'd11, 32'd13, 5'd17, 32'd143);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
